// File: rtl/port_concentrator_w_if.sv
// ---------------------------------------------------------------------------
// port_concentrator_w_if
//   Handshake bundle around the receive concentrator.
//   Byte side (from pkt_parse):   c_srdy, c_drdy, c_code[1:0], c_data[7:0]
//   Word side (to allocator):     p_srdy, p_drdy, p_data[8*nbytes-1:0],
//                                 p_bcnt[bc_sz-1:0], p_commit, p_abort
//   Modports:
//     master - the surrounding logic: drives bytes in, accepts words out
//     slave  - the concentrator itself
// ---------------------------------------------------------------------------
interface port_concentrator_w_if #(
    parameter int nbytes = 8,
    parameter int bc_sz  = 4
);
    logic                  c_srdy;
    logic                  c_drdy;
    logic [1:0]            c_code;
    logic [7:0]            c_data;
    logic                  p_srdy;
    logic                  p_drdy;
    logic [8*nbytes-1:0]   p_data;
    logic [bc_sz-1:0]      p_bcnt;
    logic                  p_commit;
    logic                  p_abort;

    modport master (
        output c_srdy, c_code, c_data, p_drdy,
        input  c_drdy, p_srdy, p_data, p_bcnt, p_commit, p_abort
    );

    modport slave (
        input  c_srdy, c_code, c_data, p_drdy,
        output c_drdy, p_srdy, p_data, p_bcnt, p_commit, p_abort
    );
endinterface

// File: rtl/port_concentrator_w.sv
// ---------------------------------------------------------------------------
// port_concentrator_w
//   Packs the coded 8-bit receive byte stream into words of nbytes bytes,
//   with a per-word valid-byte count, commit/abort marking of the last word
//   of each frame, oversize truncation and premature-SOP abort insertion.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - port_concentrator_w_if.slave (byte input side, word output side)
//   stat_commit/stat_abort/stat_drop [15:0] - only when PORT_CONC_STATS_EN
//            is defined: saturating counts of committed frames, aborted
//            frames and bytes discarded outside a frame.
//
// Build option: `define PORT_CONC_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module port_concentrator_w #(
    parameter int nbytes    = 8,
    parameter int max_words = 200,
    parameter int bc_sz     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    port_concentrator_w_if.slave  bus
`ifdef PORT_CONC_STATS_EN
    ,
    output logic [15:0]           stat_commit,
    output logic [15:0]           stat_abort,
    output logic [15:0]           stat_drop
`endif
);
    localparam int lc_w = (nbytes > 2) ? $clog2(nbytes) : 1;
    localparam int wc_w = $clog2(max_words + 1);

    localparam logic [1:0] CODE_SOP  = 2'd0;
    localparam logic [1:0] CODE_DATA = 2'd1;
    localparam logic [1:0] CODE_EOPG = 2'd2;

    typedef enum logic [1:0] {IDLE, PACK, DROP, ABINS} state_t;

    state_t              state_reg, state_next;
    logic [8*nbytes-1:0] lanes_reg, lanes_next, merged;
    logic [lc_w-1:0]     lane_cnt_reg, lane_cnt_next;
    logic [wc_w-1:0]     word_cnt_reg, word_cnt_next;
    logic [7:0]          sop_reg, sop_next;
    logic                rdy_en_reg;
    logic                p_srdy_reg, p_srdy_next;
    logic [8*nbytes-1:0] p_data_reg, p_data_next;
    logic [bc_sz-1:0]    p_bcnt_reg, p_bcnt_next;
    logic                p_commit_reg, p_commit_next;
    logic                p_abort_reg, p_abort_next;

    logic                c_drdy_int, accept, take;
    logic                issue_word, issue_lanes_only;
    logic                issue_commit, issue_abort, drop_byte;

    // rdy_en_reg keeps c_drdy low while reset is asserted and raises it on
    // the first clock after release.
    assign c_drdy_int = rdy_en_reg && (state_reg != ABINS) && (!p_srdy_reg || bus.p_drdy);
    assign accept     = bus.c_srdy && c_drdy_int;
    assign take       = p_srdy_reg && bus.p_drdy;

    // Current lanes with the incoming byte dropped into the next free lane.
    // Lanes above the fill point are always zero, so this doubles as the
    // padded word for a final partial issue.
    generate
        for (genvar gi = 0; gi < nbytes; gi++) begin : g_merge
            assign merged[8*gi +: 8] = (lane_cnt_reg == lc_w'(gi)) ? bus.c_data
                                                                   : lanes_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        lanes_next       = lanes_reg;
        lane_cnt_next    = lane_cnt_reg;
        word_cnt_next    = word_cnt_reg;
        sop_next         = sop_reg;
        p_srdy_next      = take ? 1'b0 : p_srdy_reg;
        p_data_next      = p_data_reg;
        p_bcnt_next      = p_bcnt_reg;
        p_commit_next    = p_commit_reg;
        p_abort_next     = p_abort_reg;
        issue_word       = 1'b0;
        issue_lanes_only = 1'b0;
        issue_commit     = 1'b0;
        issue_abort      = 1'b0;
        drop_byte        = 1'b0;

        case (state_reg)
            IDLE, DROP: begin
                if (accept) begin
                    if (bus.c_code == CODE_SOP) begin
                        lanes_next      = '0;
                        lanes_next[7:0] = bus.c_data;
                        lane_cnt_next   = lc_w'(1);
                        word_cnt_next   = '0;
                        state_next      = PACK;
                    end else begin
                        drop_byte = 1'b1;
                        if (state_reg == DROP && bus.c_code[1])
                            state_next = IDLE;
                    end
                end
            end
            PACK: begin
                if (accept) begin
                    case (bus.c_code)
                        CODE_SOP: begin
                            // Close the truncated frame with what is already
                            // packed; the new SOP byte waits in sop_reg.
                            issue_word       = 1'b1;
                            issue_lanes_only = 1'b1;
                            issue_abort      = 1'b1;
                            sop_next         = bus.c_data;
                            state_next       = ABINS;
                        end
                        CODE_DATA: begin
                            if (word_cnt_reg == wc_w'(max_words)) begin
                                issue_word  = 1'b1;
                                issue_abort = 1'b1;
                                state_next  = DROP;
                            end else if (lane_cnt_reg == lc_w'(nbytes - 1)) begin
                                issue_word    = 1'b1;
                                word_cnt_next = word_cnt_reg + wc_w'(1);
                            end else begin
                                lanes_next    = merged;
                                lane_cnt_next = lane_cnt_reg + lc_w'(1);
                            end
                        end
                        default: begin
                            issue_word   = 1'b1;
                            issue_commit = (bus.c_code == CODE_EOPG);
                            issue_abort  = (bus.c_code != CODE_EOPG);
                            state_next   = IDLE;
                        end
                    endcase
                end
            end
            ABINS: begin
                if (take) begin
                    lanes_next      = '0;
                    lanes_next[7:0] = sop_reg;
                    lane_cnt_next   = lc_w'(1);
                    word_cnt_next   = '0;
                    state_next      = PACK;
                end
            end
            default: state_next = IDLE;
        endcase

        // Any issue is only possible on an accepted byte, and a byte is only
        // accepted when the output register is empty or being taken.
        if (issue_word) begin
            p_srdy_next   = 1'b1;
            p_data_next   = issue_lanes_only ? lanes_reg : merged;
            p_bcnt_next   = issue_lanes_only ? bc_sz'(lane_cnt_reg)
                                             : bc_sz'(lane_cnt_reg) + bc_sz'(1);
            p_commit_next = issue_commit;
            p_abort_next  = issue_abort;
            lanes_next    = '0;
            lane_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            lanes_reg    <= '0;
            lane_cnt_reg <= '0;
            word_cnt_reg <= '0;
            sop_reg      <= '0;
            rdy_en_reg   <= 1'b0;
            p_srdy_reg   <= 1'b0;
            p_data_reg   <= '0;
            p_bcnt_reg   <= '0;
            p_commit_reg <= 1'b0;
            p_abort_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lanes_reg    <= lanes_next;
            lane_cnt_reg <= lane_cnt_next;
            word_cnt_reg <= word_cnt_next;
            sop_reg      <= sop_next;
            rdy_en_reg   <= 1'b1;
            p_srdy_reg   <= p_srdy_next;
            p_data_reg   <= p_data_next;
            p_bcnt_reg   <= p_bcnt_next;
            p_commit_reg <= p_commit_next;
            p_abort_reg  <= p_abort_next;
        end
    end

    assign bus.c_drdy   = c_drdy_int;
    assign bus.p_srdy   = p_srdy_reg;
    assign bus.p_data   = p_data_reg;
    assign bus.p_bcnt   = p_bcnt_reg;
    assign bus.p_commit = p_commit_reg;
    assign bus.p_abort  = p_abort_reg;

`ifdef PORT_CONC_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_commit <= '0;
            stat_abort  <= '0;
            stat_drop   <= '0;
        end else begin
            if (issue_commit && stat_commit != 16'hFFFF)
                stat_commit <= stat_commit + 16'd1;
            if (issue_abort && stat_abort != 16'hFFFF)
                stat_abort <= stat_abort + 16'd1;
            if (drop_byte && stat_drop != 16'hFFFF)
                stat_drop <= stat_drop + 16'd1;
        end
    end
`else
    logic unused_stat_events;
    assign unused_stat_events = ^{issue_commit, issue_abort, drop_byte};
`endif

endmodule

// File: tb/tb_port_concentrator_w.sv
module tb_port_concentrator_w;
    typedef struct packed {
        logic         commit;
        logic         abort;
        logic [4:0]   bcnt;
        logic [127:0] data;
    } word_t;

    localparam logic [1:0] SOP  = 2'd0;
    localparam logic [1:0] DAT  = 2'd1;
    localparam logic [1:0] EOPG = 2'd2;
    localparam logic [1:0] EOPB = 2'd3;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    tests_run    = 0;
    int    tests_failed = 0;
    word_t qa[$];
    word_t qb[$];

    port_concentrator_w_if #(.nbytes(8), .bc_sz(4)) ifa ();
    port_concentrator_w_if #(.nbytes(4), .bc_sz(3)) ifb ();

`ifdef PORT_CONC_STATS_EN
    logic [15:0] sc_a, sa_a, sd_a, sc_b, sa_b, sd_b;
`endif

    port_concentrator_w #(.nbytes(8), .max_words(200), .bc_sz(4)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifa)
`ifdef PORT_CONC_STATS_EN
        ,
        .stat_commit (sc_a),
        .stat_abort  (sa_a),
        .stat_drop   (sd_a)
`endif
    );

    port_concentrator_w #(.nbytes(4), .max_words(2), .bc_sz(3)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifb)
`ifdef PORT_CONC_STATS_EN
        ,
        .stat_commit (sc_b),
        .stat_abort  (sa_b),
        .stat_drop   (sd_b)
`endif
    );

    always #5 clk = ~clk;

    // Word collectors: a word counts as transferred when srdy&drdy is seen
    // mid-cycle (inputs only change just after the rising edge).
    always @(negedge clk) begin : cap
        word_t w;
        if (ifa.p_srdy && ifa.p_drdy) begin
            w.commit = ifa.p_commit;
            w.abort  = ifa.p_abort;
            w.bcnt   = 5'(ifa.p_bcnt);
            w.data   = 128'(ifa.p_data);
            qa.push_back(w);
        end
        if (ifb.p_srdy && ifb.p_drdy) begin
            w.commit = ifb.p_commit;
            w.abort  = ifb.p_abort;
            w.bcnt   = 5'(ifb.p_bcnt);
            w.data   = 128'(ifb.p_data);
            qb.push_back(w);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int which, input logic [1:0] code, input logic [7:0] data);
        int   n;
        logic rdy;
        if (which == 0) begin
            ifa.c_srdy = 1'b1; ifa.c_code = code; ifa.c_data = data;
        end else begin
            ifb.c_srdy = 1'b1; ifb.c_code = code; ifb.c_data = data;
        end
        n = 0;
        do begin
            @(negedge clk);
            rdy = (which == 0) ? ifa.c_drdy : ifb.c_drdy;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("send.timeout", 128'(0), 128'(1));
        @(posedge clk); #1;
        if (which == 0) ifa.c_srdy = 1'b0;
        else            ifb.c_srdy = 1'b0;
    endtask

    task automatic expect_word(input int which, input string tag, input logic [127:0] data,
                               input int bcnt, input logic commit, input logic abort);
        word_t w;
        int    n;
        int    sz;
        n  = 0;
        sz = (which == 0) ? qa.size() : qb.size();
        while (sz == 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
            sz = (which == 0) ? qa.size() : qb.size();
        end
        if (sz == 0) begin
            check({tag, ".timeout"}, 128'(0), 128'(1));
        end else begin
            if (which == 0) w = qa.pop_front();
            else            w = qb.pop_front();
            $display("[TB] %s: data=%0h bcnt=%0d commit=%0b abort=%0b",
                     tag, w.data, w.bcnt, w.commit, w.abort);
            check({tag, ".data"},   w.data,          data);
            check({tag, ".bcnt"},   128'(w.bcnt),    128'(bcnt));
            check({tag, ".commit"}, 128'(w.commit),  128'(commit));
            check({tag, ".abort"},  128'(w.abort),   128'(abort));
        end
        @(posedge clk); #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".p_srdy"},   128'(ifa.p_srdy),   128'(0));
        check({tag, ".p_data"},   128'(ifa.p_data),   128'(0));
        check({tag, ".p_bcnt"},   128'(ifa.p_bcnt),   128'(0));
        check({tag, ".p_commit"}, 128'(ifa.p_commit), 128'(0));
        check({tag, ".p_abort"},  128'(ifa.p_abort),  128'(0));
        check({tag, ".c_drdy"},   128'(ifa.c_drdy),   128'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.c_srdy = 1'b0; ifa.c_code = 2'd0; ifa.c_data = 8'h00; ifa.p_drdy = 1'b1;
        ifb.c_srdy = 1'b0; ifb.c_code = 2'd0; ifb.c_data = 8'h00; ifb.p_drdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_a_zero("rst");
        check("rst.b.c_drdy", 128'(ifb.c_drdy), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst.release.c_drdy", 128'(ifa.c_drdy), 128'(1));
        @(posedge clk); #1;

        // Non-SOP byte in IDLE is swallowed
        send(0, DAT, 8'h55);
        repeat (3) @(posedge clk); #1;
        check("idle.drop.noword", 128'(qa.size()), 128'(0));

        // Good frame: 10 bytes -> full word + 2-byte committed word
        send(0, SOP, 8'h01);
        for (int i = 2; i <= 9; i++) send(0, DAT, 8'(i));
        send(0, EOPG, 8'h0A);
        expect_word(0, "good.w1", 128'h0807060504030201, 8, 1'b0, 1'b0);
        expect_word(0, "good.w2", 128'h0A09,             2, 1'b1, 1'b0);

        // Backpressure with a byte waiting during the stall
        send(0, SOP, 8'h01);
        for (int i = 2; i <= 8; i++) send(0, DAT, 8'(i));
        ifa.p_drdy = 1'b0;
        ifa.c_srdy = 1'b1; ifa.c_code = DAT; ifa.c_data = 8'h09;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.c_drdy", 128'(ifa.c_drdy), 128'(0));
            check("bp.p_srdy", 128'(ifa.p_srdy), 128'(1));
            check("bp.p_data", 128'(ifa.p_data), 128'h0807060504030201);
        end
        @(posedge clk); #1;
        ifa.p_drdy = 1'b1;
        send(0, DAT, 8'h09);
        send(0, EOPG, 8'h0A);
        expect_word(0, "bp.w1", 128'h0807060504030201, 8, 1'b0, 1'b0);
        expect_word(0, "bp.w2", 128'h0A09,             2, 1'b1, 1'b0);

        // EOP bad
        send(0, SOP, 8'h11);
        send(0, DAT, 8'h12);
        send(0, DAT, 8'h13);
        send(0, EOPB, 8'h14);
        expect_word(0, "eopbad", 128'h14131211, 4, 1'b0, 1'b1);

        // Premature SOP after two bytes
        send(0, SOP, 8'h21);
        send(0, DAT, 8'h22);
        send(0, SOP, 8'hAA);
        @(negedge clk);
        check("prem.abins.c_drdy", 128'(ifa.c_drdy), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("prem.release.c_drdy", 128'(ifa.c_drdy), 128'(1));
        @(posedge clk); #1;
        send(0, DAT, 8'hBB);
        send(0, EOPG, 8'hCC);
        expect_word(0, "prem.abort", 128'h2221,   2, 1'b0, 1'b1);
        expect_word(0, "prem.next",  128'hCCBBAA, 3, 1'b1, 1'b0);

        // Premature SOP right on a word boundary -> empty abort word
        send(0, SOP, 8'h31);
        for (int i = 8'h32; i <= 8'h38; i++) send(0, DAT, 8'(i));
        send(0, SOP, 8'h41);
        send(0, EOPG, 8'h42);
        expect_word(0, "zero.w1",    128'h3837363534333231, 8, 1'b0, 1'b0);
        expect_word(0, "zero.abort", 128'h0,                0, 1'b0, 1'b1);
        expect_word(0, "zero.next",  128'h4241,             2, 1'b1, 1'b0);

        // Oversize on the small instance (nbytes=4, max_words=2)
        send(1, SOP, 8'h01);
        for (int i = 2; i <= 11; i++) send(1, DAT, 8'(i));
        send(1, EOPG, 8'h0C);
        expect_word(1, "over.w1",  128'h04030201, 4, 1'b0, 1'b0);
        expect_word(1, "over.w2",  128'h08070605, 4, 1'b0, 1'b0);
        expect_word(1, "over.cut", 128'h09,       1, 1'b0, 1'b1);
        repeat (4) @(posedge clk); #1;
        check("over.dropped.noword", 128'(qb.size()), 128'(0));
        send(1, SOP, 8'hA1);
        send(1, DAT, 8'hA2);
        send(1, DAT, 8'hA3);
        send(1, DAT, 8'hA4);
        send(1, EOPG, 8'hA5);
        expect_word(1, "over.next.w1", 128'hA4A3A2A1, 4, 1'b0, 1'b0);
        expect_word(1, "over.next.w2", 128'hA5,       1, 1'b1, 1'b0);

`ifdef PORT_CONC_STATS_EN
        check("stat.a.commit", 128'(sc_a), 128'(4));
        check("stat.a.abort",  128'(sa_a), 128'(3));
        check("stat.a.drop",   128'(sd_a), 128'(1));
        check("stat.b.commit", 128'(sc_b), 128'(1));
        check("stat.b.abort",  128'(sa_b), 128'(1));
        check("stat.b.drop",   128'(sd_b), 128'(3));
`endif

        // Reset while a word is held
        ifa.p_drdy = 1'b0;
        send(0, SOP, 8'h51);
        for (int i = 8'h52; i <= 8'h58; i++) send(0, DAT, 8'(i));
        @(negedge clk);
        check("mid.held.p_srdy", 128'(ifa.p_srdy), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_a_zero("mid.rst");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.p_drdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid.release.c_drdy", 128'(ifa.c_drdy), 128'(1));
        @(posedge clk); #1;
        check("mid.noword", 128'(qa.size()), 128'(0));
        send(0, SOP, 8'h61);
        send(0, EOPG, 8'h62);
        expect_word(0, "mid.next", 128'h6261, 2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
